// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: req/ready request handshake, rvalid/rdata response.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem read, stall-hold output slot with a
// one-entry skid, and PC redirect on jump/branch that kills any wrong-path response.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    input  logic              stall_i,
    input  logic              redirect_jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              redirect_branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0] if_pc1_o,
    output logic [5:0]        if_opcode_o,
    output logic [5:0]        if_funct_o
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              kill_q, kill_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc1_q, if_pc1_d;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              slot_free;
    logic [ADDR_W-1:0] req_pc_inc;
    logic              load;
    logic [DATA_W-1:0] load_instr;

    assign redirect        = redirect_jump_i | redirect_branch_i;
    // The branch resolves in MEM, so it is older than the jump in EX and wins.
    assign redirect_target = redirect_branch_i ? branch_target_i : jump_target_i;
    assign slot_free       = !if_valid_q || !stall_i;
    assign req_pc_inc      = req_pc_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        skid_d     = skid_q;
        load       = 1'b0;
        load_instr = skid_q;

        case (state_q)
            S_FETCH: begin
                if (imem.imem_ready) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else if (slot_free) begin
                        load       = 1'b1;
                        load_instr = imem.imem_rdata;
                        pc_d       = req_pc_inc;
                        state_d    = S_FETCH;
                    end else begin
                        skid_d  = imem.imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    load    = 1'b1;
                    pc_d    = req_pc_inc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Redirect overrides the stall and whatever the state wanted this cycle;
        // a request already in flight is marked for kill instead of being waited out.
        if (redirect) begin
            pc_d = redirect_target;
            load = 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem.imem_ready) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_d = S_FETCH;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end

        if (redirect) begin
            if_valid_d = 1'b0;
        end else if (load) begin
            if_valid_d = 1'b1;
        end else if (if_valid_q && !stall_i) begin
            if_valid_d = 1'b0;
        end else begin
            if_valid_d = if_valid_q;
        end
        if_instr_d = load ? load_instr : if_instr_q;
        if_pc1_d   = load ? req_pc_inc : if_pc1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            kill_q     <= 1'b0;
            skid_q     <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc1_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            skid_q     <= skid_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc1_q   <= if_pc1_d;
        end
    end

    assign imem.imem_req  = rst_n && (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;

    assign if_valid_o  = if_valid_q;
    assign if_instr_o  = if_instr_q;
    assign if_pc1_o    = if_pc1_q;
    assign if_opcode_o = if_instr_q[31:26];
    assign if_funct_o  = if_instr_q[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run scored against an
// instruction-stream model (next expected fetch address, memory contents as a function).
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst2_n;
    logic stall, rj, rb;
    logic [31:0] jt, bt;
    logic if_valid;
    logic [31:0] if_instr, if_pc1;
    logic [5:0] op, fn;

    logic if2_valid;
    logic [31:0] if2_instr, if2_pc1;
    logic [5:0] op2, fn2;
    logic zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;

    int checks = 0;
    int failures = 0;
    bit mem_rand = 1'b0;
    int mem_delay = 0;

    fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem(bus),
        .stall_i(stall), .redirect_jump_i(rj), .jump_target_i(jt),
        .redirect_branch_i(rb), .branch_target_i(bt),
        .if_valid_o(if_valid), .if_instr_o(if_instr), .if_pc1_o(if_pc1),
        .if_opcode_o(op), .if_funct_o(fn)
    );

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem(bus2),
        .stall_i(zero1), .redirect_jump_i(zero1), .jump_target_i(zero32),
        .redirect_branch_i(zero1), .branch_target_i(zero32),
        .if_valid_o(if2_valid), .if_instr_o(if2_instr), .if_pc1_o(if2_pc1),
        .if_opcode_o(op2), .if_funct_o(fn2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0022_1820;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory for dut: decides ready just after each edge for the coming edge, and
    // returns data 1 + cnt cycles after acceptance.
    initial begin
        bit pend;
        logic [31:0] paddr;
        int cnt;
        pend = 1'b0; paddr = '0; cnt = 0;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                pend = 1'b0; bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0;
            end else begin
                bus.imem_rvalid = 1'b0;
                if (pend) begin
                    if (cnt == 0) begin
                        bus.imem_rvalid = 1'b1;
                        bus.imem_rdata  = mem_word(paddr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                bus.imem_ready = mem_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
                if (bus.imem_req && bus.imem_ready) begin
                    pend  = 1'b1;
                    paddr = bus.imem_addr;
                    cnt   = mem_rand ? int'($urandom_range(0, 2)) : mem_delay;
                end
            end
        end
    end

    initial begin
        bit pend2;
        logic [31:0] paddr2;
        pend2 = 1'b0; paddr2 = '0;
        bus2.imem_ready = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst2_n) begin
                pend2 = 1'b0; bus2.imem_ready = 1'b0; bus2.imem_rvalid = 1'b0;
            end else begin
                bus2.imem_rvalid = pend2;
                bus2.imem_rdata  = mem_word(paddr2);
                pend2 = 1'b0;
                bus2.imem_ready = 1'b1;
                if (bus2.imem_req) begin
                    pend2  = 1'b1;
                    paddr2 = bus2.imem_addr;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 1'b0; rj = 1'b0; rb = 1'b0; jt = '0; bt = '0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h expected 0", if_instr); end
        checks++; if (if_pc1 !== 32'h0) begin failures++; $display("FAIL rst_pc1: got %h expected 0", if_pc1); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rel_req: got %b expected 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rel_addr: got %h expected 0", bus.imem_addr); end
    endtask

    task automatic test_sequential();
        int k = 0;
        for (int c = 0; c < 30 && k < 3; c++) begin
            @(posedge clk); #2;
            if (if_valid === 1'b1) begin
                checks++;
                if (if_pc1 !== 32'(k + 1) || if_instr !== mem_word(32'(k))) begin
                    failures++;
                    $display("FAIL seq_%0d: got instr=%h pc1=%h expected instr=%h pc1=%h",
                             k, if_instr, if_pc1, mem_word(32'(k)), 32'(k + 1));
                end
                if (k == 0) begin
                    checks++;
                    if (op !== 6'h00 || fn !== 6'h20) begin
                        failures++;
                        $display("FAIL rtype_fields: got op=%h funct=%h expected op=00 funct=20", op, fn);
                    end
                end
                k++;
            end
        end
        checks++; if (k != 3) begin failures++; $display("FAIL seq_count: got %0d expected 3", k); end
    endtask

    task automatic test_stall_hold();
        bit got = 1'b0;
        logic [31:0] h_instr, h_pc1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #2;
            if (if_valid === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL hold_find: got no valid expected valid"); end
        h_instr = if_instr; h_pc1 = if_pc1;
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #2;
            checks++;
            if (if_valid !== 1'b1 || if_instr !== h_instr || if_pc1 !== h_pc1) begin
                failures++;
                $display("FAIL hold_%0d: got v=%b instr=%h pc1=%h expected v=1 instr=%h pc1=%h",
                         c, if_valid, if_instr, if_pc1, h_instr, h_pc1);
            end
        end
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL hold_req: got %b expected 0", bus.imem_req); end
        stall = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (if_valid !== 1'b1 || if_pc1 !== 32'(h_pc1 + 1) || if_instr !== mem_word(h_pc1)) begin
            failures++;
            $display("FAIL hold_release: got v=%b instr=%h pc1=%h expected v=1 instr=%h pc1=%h",
                     if_valid, if_instr, if_pc1, mem_word(h_pc1), 32'(h_pc1 + 1));
        end
    endtask

    task automatic test_branch_kill();
        bit got = 1'b0;
        mem_delay = 1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #2;
            if (bus.imem_req === 1'b0 && bus.imem_rvalid === 1'b0) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL bk_find: got no WAIT cycle expected one"); end
        rb = 1'b1; bt = 32'h40; jt = 32'h1234;
        @(posedge clk); #2;
        rb = 1'b0;
        checks++;
        if (bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL bk_wait: got req=%b valid=%b expected req=0 valid=0", bus.imem_req, if_valid);
        end
        @(posedge clk); #2;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL bk_drop: got valid=%b expected 0", if_valid); end
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL bk_addr: got req=%b addr=%h expected req=1 addr=00000040", bus.imem_req, bus.imem_addr);
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #2;
            if (if_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || if_pc1 !== 32'h41 || if_instr !== mem_word(32'h40)) begin
            failures++;
            $display("FAIL bk_first: got v=%b instr=%h pc1=%h expected v=1 instr=%h pc1=00000041",
                     got, if_instr, if_pc1, mem_word(32'h40));
        end
        mem_delay = 0;
    endtask

    task automatic test_redirect_priority();
        bit got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #2;
            if (bus.imem_req === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL pri_find: got no request expected one"); end
        rj = 1'b1; jt = 32'h10; rb = 1'b1; bt = 32'h80;
        @(posedge clk); #2;
        rj = 1'b0; rb = 1'b0;
        checks++;
        if (bus.imem_addr !== 32'h80 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL pri_addr: got addr=%h valid=%b expected addr=00000080 valid=0", bus.imem_addr, if_valid);
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #2;
            if (if_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || if_pc1 !== 32'h81 || if_instr !== mem_word(32'h80)) begin
            failures++;
            $display("FAIL pri_first: got v=%b instr=%h pc1=%h expected v=1 instr=%h pc1=00000081",
                     got, if_instr, if_pc1, mem_word(32'h80));
        end
    endtask

    task automatic test_reset_pc_wrap();
        bit got = 1'b0;
        @(posedge clk); #2;
        rst2_n = 1'b1;
        #1;
        checks++;
        if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_first_addr: got req=%b addr=%h expected req=1 addr=ffffffff", bus2.imem_req, bus2.imem_addr);
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #2;
            if (if2_valid === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL wrap_valid: got no valid expected valid"); end
        checks++; if (if2_pc1 !== 32'h0) begin failures++; $display("FAIL wrap_pc1: got %h expected 00000000", if2_pc1); end
        checks++;
        if (if2_instr !== mem_word(32'hFFFF_FFFF)) begin
            failures++;
            $display("FAIL wrap_instr: got %h expected %h", if2_instr, mem_word(32'hFFFF_FFFF));
        end
        checks++;
        if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next_addr: got req=%b addr=%h expected req=1 addr=00000000", bus2.imem_req, bus2.imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, h_instr, h_pc1, e;
        bit hold_pend = 1'b0;
        bit redir;
        int idle = 0;
        int consumed = 0;
        int r;
        mem_rand = 1'b1;
        @(posedge clk); #2;
        stall = 1'b0; rb = 1'b0; rj = 1'b1; jt = $urandom;
        exp_pc = jt;
        h_instr = '0; h_pc1 = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #2;
            if (hold_pend) begin
                checks++;
                if (if_valid !== 1'b1 || if_instr !== h_instr || if_pc1 !== h_pc1) begin
                    failures++;
                    $display("FAIL rnd_hold: got v=%b instr=%h pc1=%h expected v=1 instr=%h pc1=%h",
                             if_valid, if_instr, if_pc1, h_instr, h_pc1);
                end
            end
            stall = ($urandom_range(0, 9) < 3);
            r = $urandom_range(0, 29);
            rj = (r == 0) || (r == 2);
            rb = (r == 1) || (r == 2);
            jt = $urandom;
            bt = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            #1;
            redir = rj || rb;
            if (if_valid === 1'b1 && !stall && !redir) begin
                e = mem_word(exp_pc);
                checks++;
                if (if_instr !== e || if_pc1 !== 32'(exp_pc + 1) || op !== e[31:26] || fn !== e[5:0]) begin
                    failures++;
                    $display("FAIL rnd_instr: got instr=%h pc1=%h op=%h fn=%h expected instr=%h pc1=%h",
                             if_instr, if_pc1, op, fn, e, 32'(exp_pc + 1));
                end
                exp_pc = exp_pc + 32'd1;
                consumed++;
                idle = 0;
            end else begin
                idle++;
            end
            hold_pend = (if_valid === 1'b1) && stall && !redir;
            h_instr = if_instr; h_pc1 = if_pc1;
            if (redir) exp_pc = rb ? bt : jt;
            if (idle > 80) begin
                checks++; failures++;
                $display("FAIL rnd_progress: got %0d idle cycles expected at most 80", idle);
                break;
            end
        end
        stall = 1'b0; rj = 1'b0; rb = 1'b0; mem_rand = 1'b0;
        checks++;
        if (consumed < 40) begin
            failures++;
            $display("FAIL rnd_throughput: got %0d instrs expected at least 40", consumed);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || bus.imem_req !== 1'b0 || if_pc1 !== 32'h0 || if_instr !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: got v=%b req=%b pc1=%h instr=%h expected all zero",
                     if_valid, bus.imem_req, if_pc1, if_instr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_branch_kill();
        test_redirect_priority();
        test_reset_pc_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
